// File: rtl/dca_matrix_mac_inst_queue_pkg.sv
// rtl/dca_matrix_mac_inst_queue_pkg.sv - shared types and widths for the MAC instruction queue
package dca_matrix_mac_inst_queue_pkg;

    localparam int DONE_CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mac_q_state_e;

    // Opcode byte plus three operand address fields sized for the matrix.
    function automatic int bw_dca_matrix_mac_inst(input int msize);
        return 8 + 3 * $clog2(4 * msize * msize);
    endfunction

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dca_inst_fifo.sv
// rtl/dca_inst_fifo.sv - circular instruction buffer with head-keeping flush
module dca_inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic                       keep_head_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             write_en;

    assign write_en = push_i & ~flush_i;
    assign head_o   = mem_q[rd_ptr_q];
    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            if (keep_head_i) begin
                // Everything behind the head is dropped; a same-cycle pop retires the head too.
                wr_ptr_d = rd_ptr_q + PTR_W'(1);
                rd_ptr_d = pop_i ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
                count_d  = pop_i ? CNT_W'(0) : CNT_W'(1);
            end else begin
                rd_ptr_d = wr_ptr_q;
                count_d  = '0;
            end
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/dca_matrix_mac_inst_queue.sv
// rtl/dca_matrix_mac_inst_queue.sv - MAC instruction queue issuing to the step sequencer
module dca_matrix_mac_inst_queue
    import dca_matrix_mac_inst_queue_pkg::*;
#(
    parameter int MATRIX_SIZE_PARA = 8,
    parameter int DEPTH            = 4,
    parameter int BW_INST          = bw_dca_matrix_mac_inst(MATRIX_SIZE_PARA)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      enable,
    input  logic                      push_valid,
    input  logic [BW_INST-1:0]        push_inst,
    output logic                      push_ready,
    output logic                      seq_req,
    output logic [BW_INST-1:0]        seq_inst,
    input  logic                      seq_busy,
    input  logic                      seq_done,
    output logic [occ_w(DEPTH)-1:0]   num_entries,
    output logic [DONE_CNT_W-1:0]     done_count,
    output logic                      running,
    output logic                      all_done_pulse
);

    localparam int CNT_W = occ_w(DEPTH);

    mac_q_state_e          state_q, state_d;
    logic [DONE_CNT_W-1:0] done_count_q, done_count_d;
    logic                  pulse_q, pulse_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_push;
    logic                  flush;
    logic                  retire;

    assign push_ready = enable & ~fifo_full;
    // A push coinciding with clear is acknowledged but never stored.
    assign fifo_push  = push_valid & push_ready & ~clear;
    assign flush      = enable & clear;

    dca_inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BW_INST)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (push_inst),
        .pop_i       (retire),
        .flush_i     (flush),
        .keep_head_i (state_q == ST_RUN),
        .head_o      (seq_inst),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        seq_req = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                seq_req = enable & ~fifo_empty & ~seq_busy & ~clear;
                if (seq_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (enable & seq_done) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done_count_d = done_count_q + DONE_CNT_W'(retire);
        pulse_d      = retire & (flush | ((fifo_count == CNT_W'(1)) & ~fifo_push));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            done_count_q <= '0;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_count_q <= done_count_d;
            pulse_q      <= pulse_d;
        end
    end

    assign num_entries    = fifo_count;
    assign done_count     = done_count_q;
    assign running        = (state_q == ST_RUN);
    assign all_done_pulse = pulse_q;

endmodule

// File: tb/tb_dca_matrix_mac_inst_queue.sv
// tb/tb_dca_matrix_mac_inst_queue.sv - scoreboard bench for the MAC instruction queue
module tb_dca_matrix_mac_inst_queue;
    import dca_matrix_mac_inst_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = bw_dca_matrix_mac_inst(8);
    localparam int CW    = occ_w(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          enable = 1'b0;
    logic          push_valid = 1'b0;
    logic [W-1:0]  push_inst = '0;
    logic          seq_busy = 1'b0;
    logic          seq_done = 1'b0;
    logic          push_ready;
    logic          seq_req;
    logic [W-1:0]  seq_inst;
    logic [CW-1:0] num_entries;
    logic [15:0]   done_count;
    logic          running;
    logic          all_done_pulse;

    dca_matrix_mac_inst_queue #(
        .MATRIX_SIZE_PARA (8),
        .DEPTH            (DEPTH),
        .BW_INST          (W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .enable         (enable),
        .push_valid     (push_valid),
        .push_inst      (push_inst),
        .push_ready     (push_ready),
        .seq_req        (seq_req),
        .seq_inst       (seq_inst),
        .seq_busy       (seq_busy),
        .seq_done       (seq_done),
        .num_entries    (num_entries),
        .done_count     (done_count),
        .running        (running),
        .all_done_pulse (all_done_pulse)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_issue[$];
    logic [W-1:0] cur_inst = '0;
    bit           m_run = 0;
    int           m_done = 0;
    bit           exp_pulse = 0;
    bit           started = 0;
    int           cd = -1;
    int           mcnt;
    bit           exp_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compares every observable output against the bench's queue model.
    always @(negedge clk) begin
        if (started) begin
            mcnt = exp_issue.size() + int'(m_run);
            chk("push_ready", 64'(push_ready), 64'(enable && mcnt < DEPTH));
            chk("num_entries", 64'(num_entries), 64'(mcnt));
            chk("done_count", 64'(done_count), 64'(m_done & 32'hFFFF));
            chk("running", 64'(running), 64'(m_run));
            chk("all_done_pulse", 64'(all_done_pulse), 64'(exp_pulse));
            exp_req = !m_run && enable && exp_issue.size() > 0 && !seq_busy && !clear;
            chk("seq_req", 64'(seq_req), 64'(exp_req));
            if (m_run) chk("seq_inst_hold", 64'(seq_inst), 64'(cur_inst));
            if (seq_req && !m_run && exp_issue.size() > 0) begin
                cur_inst = exp_issue.pop_front();
                chk("seq_inst_issue", 64'(seq_inst), 64'(cur_inst));
                m_run = 1;
            end
        end
    end

    // One clock of stimulus: settle the model for the edge just taken, then drive new inputs.
    task automatic step(input bit en, input bit pv, input logic [W-1:0] pd, input bit clr, input bit busy);
        bit acc;
        bit ret;
        int cnt;
        @(posedge clk);
        #1;
        cnt = exp_issue.size() + int'(m_run);
        ret = enable && seq_done;
        acc = enable && push_valid && !clear && cnt < DEPTH;
        exp_pulse = 0;
        if (enable && clear) exp_issue.delete();
        if (ret) begin
            m_run  = 0;
            m_done = m_done + 1;
            exp_pulse = clear || (exp_issue.size() == 0 && !acc);
        end
        if (acc) exp_issue.push_back(push_inst);
        if (m_run && cd < 0) cd = int'($urandom_range(0, 4));
        enable     = en;
        push_valid = pv;
        push_inst  = pd;
        clear      = clr;
        seq_busy   = busy;
        seq_done   = 0;
        if (en && m_run) begin
            if (cd == 0) begin
                seq_done = 1;
                cd = -1;
            end else begin
                cd = cd - 1;
            end
        end
    endtask

    bit           r_en, r_pv, r_clr, r_busy;
    logic [W-1:0] fill_vals [5];

    initial begin
        fill_vals[0] = W'(32'h1111_000A);
        fill_vals[1] = W'(32'h2222_000B);
        fill_vals[2] = W'(32'h3333_000C);
        fill_vals[3] = W'(32'h4444_000D);
        fill_vals[4] = W'(32'h5555_000E);
        repeat (3) @(posedge clk);
        #1;
        rst     = 0;
        enable  = 1;
        started = 1;
        @(negedge clk);
        chk("reset_seq_inst", 64'(seq_inst), 64'(0));

        step(1, 1, W'(32'hCAFE_00A5), 0, 0);
        repeat (12) step(1, 0, '0, 0, 0);

        for (int i = 0; i < 5; i++) step(1, 1, fill_vals[i], 0, 1);
        step(1, 0, '0, 0, 1);
        repeat (40) step(1, 0, '0, 0, 0);

        for (int i = 0; i < 3; i++) step(1, 1, fill_vals[i], 0, 1);
        step(1, 0, '0, 0, 0);
        step(1, 1, W'(32'h0BAD_0BAD), 1, 0);
        repeat (12) step(1, 0, '0, 0, 0);

        for (int i = 0; i < 3; i++) step(1, 1, fill_vals[i+1], 0, 1);
        repeat (5) step(0, 1, W'(32'h7777_7777), 0, 0);
        repeat (40) step(1, 0, '0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            r_en   = ($urandom % 16) != 0;
            r_pv   = ($urandom % 2) != 0;
            r_clr  = ($urandom % 25) == 0;
            r_busy = ($urandom % 4) == 0;
            step(r_en, r_pv, W'($urandom), r_clr, r_busy);
        end

        for (int n = 0; n < 200; n++) begin
            if (exp_issue.size() == 0 && !m_run && n > 2) break;
            step(1, 0, '0, 0, 0);
        end
        step(1, 0, '0, 0, 0);
        @(negedge clk);
        chk("drain_empty", 64'(exp_issue.size() + int'(m_run)), 64'(0));
        chk("done_total_nonzero", 64'(m_done > 10), 64'(1));
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dca_matrix_mac_inst_queue.md
# dca_matrix_mac_inst_queue

Instruction queue directly upstream of the DCA matrix MAC step sequencer. Buffers `BW_DCA_MATRIX_MAC_INST`-wide MAC instructions written by the control path. Issues them one at a time over the sequencer's request/busy/done handshake. Holds each issued instruction stable until the sequencer reports completion, then retires it and keeps completion status.

## Interface
Parameters:
- MATRIX_SIZE_PARA, 8, matrix size parameter; passed through only so the instruction width is consistent with the sequencer.
- DEPTH, 4, number of queued instructions; power of two, at least 2.
- BW_INST, `BW_DCA_MATRIX_MAC_INST`, instruction width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of unissued entries.
- enable  in  1  global advance enable; when low, all registers hold.
- push_valid  in  1  new instruction offered.
- push_inst  in  BW_INST  instruction payload.
- push_ready  out  1  queue can accept; equals enable & ~full.
- seq_req  out  1  issue request to the sequencer's request input.
- seq_inst  out  BW_INST  head instruction to the sequencer's instruction input.
- seq_busy  in  1  sequencer busy status.
- seq_done  in  1  sequencer single-cycle completion pulse.
- num_entries  out  clog2(DEPTH+1)  occupancy, including the running entry.
- done_count  out  16  instructions retired; wraps from 0xFFFF to 0.
- running  out  1  an instruction is currently issued.
- all_done_pulse  out  1  one-cycle pulse when the queue becomes completely empty by a retirement.

## Operation
- Storage: circular buffer with DEPTH entries, a write pointer, a read pointer and an occupancy counter. full = (count==DEPTH); empty = (count==0).
- Push: when push_valid & push_ready, write mem[wr_ptr], advance wr_ptr modulo DEPTH, count+1.
- FSM states:
  - IDLE: seq_req = enable & ~empty & ~seq_busy & ~clear. When seq_req is asserted, go to RUN on the next edge.
  - RUN: seq_req = 0 and running = 1. When enable & seq_done, retire the head: advance rd_ptr, count−1, done_count+1, go to IDLE.
  - seq_done received in IDLE is ignored. seq_busy in RUN is ignored.
- seq_inst = mem[rd_ptr], driven combinationally. It must stay unchanged for the whole RUN period, because the sequencer reads the instruction continuously.
- A push and a retirement in the same cycle leave count unchanged; both pointers advance.
- clear:
  - In IDLE: drop all entries (count=0, rd_ptr=wr_ptr).
  - In RUN: drop every entry except the head. The head completes normally, and count becomes 1 on the next edge.
  - A push in the same cycle as clear is discarded; push_ready is still reported.
- all_done_pulse is registered. It asserts on the cycle after a retirement that leaves count==0, with no simultaneous push.
- enable low: push_ready=0, seq_req=0, and the FSM, pointers and counters hold. A seq_done pulse that arrives while enable is low is lost. Because the sequencer shares the same enable, such a pulse cannot occur.

## Timing
- Reset values: state IDLE, pointers 0, count 0, storage all zero (so seq_inst=0), done_count 0, seq_req 0, running 0, all_done_pulse 0. push_ready is 1 once enable is high.
- Push-to-issue latency: a push at edge N gives seq_req high in cycle N+1, if the FSM is IDLE and seq_busy is low.
- seq_req lasts exactly one cycle per instruction.
- Retirement: seq_done at edge M returns the FSM to IDLE. The next seq_req is in cycle M+1, a one-cycle bubble between instructions.
- num_entries, done_count and running are registered and update on the edge that causes the event.
- rst asserted mid-RUN aborts the instruction and discards all state. The sequencer is reset from the same source.

## Structure
- Shared package:
  - FSM state encoding (IDLE=0, RUN=1).
  - Occupancy width function clog2(DEPTH+1).
  - Width of done_count (16).
- Sub-module: dca_inst_fifo, a generic circular buffer with:
  - push and pop interface;
  - head-keeping flush input;
  - full/empty/count outputs.
- The FSM, done counter and pulse logic live in the top module.

## Test plan
- Reset, then enable=1 → push_ready=1, seq_req=0, seq_inst=0, num_entries=0, done_count=0.
- Push instruction A (0x…A5) at cycle 0, seq_busy=0 → seq_req=1 only in cycle 1; seq_inst=A until seq_done at cycle 10; done_count=1 at cycle 11; all_done_pulse high in cycle 11 only.
- Push DEPTH+1 instructions back-to-back with the sequencer stalled → push_ready drops after 4 pushes; the 5th is held by push_valid; FIFO order A, B, C, D is preserved on seq_inst across four done pulses.
- Push and seq_done in the same cycle with count=2 → count stays 2; the next seq_req comes exactly one cycle later with the next entry.
- clear in RUN with 3 entries → num_entries=1; the running head is unchanged; after seq_done, count=0, done_count+1 and all_done_pulse=1.
- enable=0 for 5 cycles with entries pending → no seq_req, counters frozen; issue resumes the cycle after enable returns high.
